// File: rtl/e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl -- multiply/divide unit controller for the E pipeline stage.
//
// Holds the architectural HI/LO registers and sequences multi-cycle
// mult/multu/div/divu operations. The full 64-bit result is computed at the
// start edge, parked in res_hi/res_lo, and copied into HI/LO when the busy
// countdown expires. Up to that point the unit only reports busy, so mfhi/mflo
// keep returning the old HI/LO values.
//
// Ports
//   clk        : single clock, rising-edge active
//   reset      : synchronous, active-low reset
//   E_MDOp     : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//                7 mthi, 8 mtlo, 9-15 none
//   E_RsData   : operand A; source value for mthi/mtlo
//   E_RtData   : operand B
//   D_IsMD     : the instruction in the D stage uses the MD unit
//   E_MDStart  : an operation launches this cycle (combinational)
//   E_MDBusy   : an operation is in progress (registered)
//   E_MDData   : HI for mfhi, LO for mflo, otherwise 0 (combinational)
//   MD_Stall   : the D-stage MD instruction has to wait
// ---------------------------------------------------------------------------
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_RsData,
  input  logic [31:0] E_RtData,
  input  logic        D_IsMD,
  output logic        E_MDStart,
  output logic        E_MDBusy,
  output logic [31:0] E_MDData,
  output logic        MD_Stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] res_hi, res_lo;
  logic        busy_q;

  logic op_mul, op_div, in_idle, last_cycle;

  assign op_mul     = (E_MDOp == 4'd1) || (E_MDOp == 4'd2);
  assign op_div     = (E_MDOp == 4'd3) || (E_MDOp == 4'd4);
  assign in_idle    = (state == IDLE);
  assign last_cycle = (cnt <= 4'd1);

  // Result arithmetic, evaluated on the live operands and captured only on
  // the start edge.
  logic signed [63:0] mul_a_s, mul_b_s, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] div_a_s, div_b_s, quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;

  assign mul_a_s = {{32{E_RsData[31]}}, E_RsData};
  assign mul_b_s = {{32{E_RtData[31]}}, E_RtData};
  assign prod_s  = mul_a_s * mul_b_s;
  assign prod_u  = {32'd0, E_RsData} * {32'd0, E_RtData};
  assign div_a_s = E_RsData;
  assign div_b_s = E_RtData;
  assign quot_s  = div_a_s / div_b_s;
  assign rem_s   = div_a_s % div_b_s;
  assign quot_u  = E_RsData / E_RtData;
  assign rem_u   = E_RsData % E_RtData;

  // State register; busy is registered alongside so it never depends on the
  // current op inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);
    end
  end

  // Next-state logic. Ops presented while busy are ignored entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (op_mul)      next_state = MUL;
        else if (op_div) next_state = DIV;
      end
      MUL, DIV: begin
        if (last_cycle) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs. Start is gated by IDLE, so it can never coincide with busy.
  always_comb begin
    E_MDStart = in_idle && (op_mul || op_div);
    E_MDBusy  = busy_q;
    E_MDData  = 32'd0;
    case (E_MDOp)
      4'd5:    E_MDData = hi;
      4'd6:    E_MDData = lo;
      default: E_MDData = 32'd0;
    endcase
    MD_Stall = D_IsMD && (E_MDStart || busy_q);
  end

  // Counter, pending result and HI/LO. A zero divisor parks the current HI/LO
  // in the result registers, so the final write-back leaves them unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= 4'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          case (E_MDOp)
            4'd1: begin
              cnt    <= MULT_CNT;
              res_hi <= prod_s[63:32];
              res_lo <= prod_s[31:0];
            end
            4'd2: begin
              cnt    <= MULT_CNT;
              res_hi <= prod_u[63:32];
              res_lo <= prod_u[31:0];
            end
            4'd3: begin
              cnt <= DIV_CNT;
              if (E_RtData == 32'd0) begin
                res_hi <= hi;
                res_lo <= lo;
              end else begin
                res_hi <= rem_s;
                res_lo <= quot_s;
              end
            end
            4'd4: begin
              cnt <= DIV_CNT;
              if (E_RtData == 32'd0) begin
                res_hi <= hi;
                res_lo <= lo;
              end else begin
                res_hi <= rem_u;
                res_lo <= quot_u;
              end
            end
            4'd7:    hi <= E_RsData;
            4'd8:    lo <= E_RsData;
            default: ;
          endcase
        end
        MUL, DIV: begin
          if (last_cycle) begin
            hi  <= res_hi;
            lo  <= res_lo;
            cnt <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule
